// File: rtl/io_ram_uart_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : io_ram_uart_bus_if
// Description : Load/store bus between the core and the RAM/UART block.
//               The core drives address, store data, strobes and size code;
//               the slave returns combinational load data and misalign flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_ram_uart_bus_if;
  logic [31:0] address;
  logic [31:0] wd;
  logic        we;
  logic        re;
  logic [2:0]  mem_ctrl;
  logic [31:0] rd;
  logic        misalign;

  modport master (output address, wd, we, re, mem_ctrl, input rd, misalign);
  modport slave  (input address, wd, we, re, mem_ctrl, output rd, misalign);
endinterface
`default_nettype wire

// File: rtl/io_ram_uart_bus.sv
`default_nettype none
// ============================================================================
// Module      : io_ram_uart_bus
// Description : Byte-addressed data RAM with RISC-V sized loads/stores plus a
//               memory-mapped 8N1 UART (baud divisor, RX/TX FIFOs, sticky
//               error flags, registered RX interrupt).
// Revision    : 1.0 - initial release
// ============================================================================
module io_ram_uart_bus #(
  parameter int          RAM_WORDS   = 1024,
  parameter logic [31:0] IO_BASE     = 32'h00400100,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd95
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  io_ram_uart_bus_if.slave  bus,
  input  wire logic         rx,
  output logic              tx,
  output logic              irq
);
  localparam int          c_RAM_AW    = $clog2(RAM_WORDS);
  localparam int          c_PW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] c_RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [c_PW:0] c_PTR_ONE = (c_PW+1)'(1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_DATA  = 2'd2;
  localparam logic [1:0] c_ST_STOP  = 2'd3;

  // ---------------- address decode and access size ----------------
  logic [31:0] w_io_off;
  logic        w_is_ram, w_is_io, w_byte, w_half;
  logic [2:0]  w_reg;
  assign w_is_ram = bus.address < c_RAM_BYTES;
  assign w_io_off = bus.address - IO_BASE;
  assign w_is_io  = (bus.address >= IO_BASE) && (w_io_off < 32'h14);
  assign w_reg    = w_io_off[4:2];
  assign w_byte   = bus.mem_ctrl[1:0] == 2'd0;
  assign w_half   = bus.mem_ctrl[1:0] == 2'd1;
  // Codes 3/6/7 fall through to word size because only [1:0] selects size.
  assign bus.misalign = (w_half & bus.address[0]) |
                        (~w_byte & ~w_half & (bus.address[1:0] != 2'b00));

  // ---------------- RAM ----------------
  logic [31:0]         r_mem [RAM_WORDS];
  logic [c_RAM_AW-1:0] w_widx;
  logic [31:0]         w_word, w_wdata, w_ram_rd;
  logic [3:0]          w_be;
  logic [7:0]          w_lb;
  logic [15:0]         w_lh;
  assign w_widx = bus.address[c_RAM_AW+1:2];
  assign w_word = r_mem[w_widx];

  // Byte enables and lane-replicated store data from size and low address bits
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.wd;
    if (w_byte) begin
      w_be    = 4'b0001 << bus.address[1:0];
      w_wdata = {4{bus.wd[7:0]}};
    end else if (w_half) begin
      w_be    = bus.address[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{bus.wd[15:0]}};
    end
  end

  // Byte-lane RAM write; misaligned stores are dropped
  always_ff @(posedge clk) begin
    if (bus.we && w_is_ram && !bus.misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][i*8 +: 8] <= w_wdata[i*8 +: 8];
      end
    end
  end

  // Lane select plus sign/zero extension for loads
  always_comb begin
    case (bus.address[1:0])
      2'd0:    w_lb = w_word[7:0];
      2'd1:    w_lb = w_word[15:8];
      2'd2:    w_lb = w_word[23:16];
      default: w_lb = w_word[31:24];
    endcase
    w_lh = bus.address[1] ? w_word[31:16] : w_word[15:0];
    if (w_byte)      w_ram_rd = bus.mem_ctrl[2] ? {24'd0, w_lb} : {{24{w_lb[7]}}, w_lb};
    else if (w_half) w_ram_rd = bus.mem_ctrl[2] ? {16'd0, w_lh} : {{16{w_lh[15]}}, w_lh};
    else             w_ram_rd = w_word;
  end

  // ---------------- UART registers and FIFOs ----------------
  logic [2:0]  r_ctrl;
  logic [15:0] r_baud;
  logic        r_overrun, r_frame_err, r_irq, r_tx;
  logic [7:0]  r_rxf [FIFO_DEPTH];
  logic [7:0]  r_txf [FIFO_DEPTH];
  logic [c_PW:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
  logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic w_io_wr, w_rx_pop, w_rx_push, w_tx_push, w_tx_pop, w_set_ov;
  logic w_rx_stop_ok, w_rx_stop_bad, w_tx_busy;
  logic [1:0]  r_rx_state, w_rx_next, r_tx_state, w_tx_next;
  logic [7:0]  r_rx_sh, r_tx_sh;
  logic [31:0] w_io_rd;

  assign w_rx_empty = r_rx_wp == r_rx_rp;
  assign w_rx_full  = (r_rx_wp[c_PW] != r_rx_rp[c_PW]) &&
                      (r_rx_wp[c_PW-1:0] == r_rx_rp[c_PW-1:0]);
  assign w_tx_empty = r_tx_wp == r_tx_rp;
  assign w_tx_full  = (r_tx_wp[c_PW] != r_tx_rp[c_PW]) &&
                      (r_tx_wp[c_PW-1:0] == r_tx_rp[c_PW-1:0]);

  assign w_io_wr   = bus.we && w_is_io;
  assign w_rx_pop  = bus.re && w_is_io && (w_reg == 3'd1) && !w_rx_empty;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the push
  assign w_rx_push = w_rx_stop_ok && (!w_rx_full || w_rx_pop);
  assign w_set_ov  = w_rx_stop_ok && w_rx_full && !w_rx_pop;
  assign w_tx_push = w_io_wr && (w_reg == 3'd2) && (!w_tx_full || w_tx_pop);

  // Control/status registers, sticky flags (set beats clear) and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl      <= 3'd0;
      r_baud      <= DEFAULT_DIV;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_io_wr && w_reg == 3'd0) r_ctrl <= bus.wd[2:0];
      if (w_io_wr && w_reg == 3'd3) r_baud <= (bus.wd[15:0] < 16'd4) ? 16'd4 : bus.wd[15:0];
      r_overrun   <= w_set_ov      | (r_overrun   & ~(w_io_wr && w_reg == 3'd4 && bus.wd[4]));
      r_frame_err <= w_rx_stop_bad | (r_frame_err & ~(w_io_wr && w_reg == 3'd4 && bus.wd[5]));
      r_irq       <= r_ctrl[2] & ~w_rx_empty;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + c_PTR_ONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_PTR_ONE;
      if (w_tx_push) r_tx_wp <= r_tx_wp + c_PTR_ONE;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_PTR_ONE;
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rxf[r_rx_wp[c_PW-1:0]] <= r_rx_sh;
    if (w_tx_push) r_txf[r_tx_wp[c_PW-1:0]] <= bus.wd[7:0];
  end

  // IO register read mux
  always_comb begin
    w_io_rd = 32'd0;
    case (w_reg)
      3'd0: w_io_rd = {29'd0, r_ctrl};
      3'd1: w_io_rd = {24'd0, w_rx_empty ? 8'h00 : r_rxf[r_rx_rp[c_PW-1:0]]};
      3'd3: w_io_rd = {16'd0, r_baud};
      3'd4: w_io_rd = {25'd0, w_tx_busy, r_frame_err, r_overrun,
                       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};
      default: w_io_rd = 32'd0;
    endcase
  end

  assign bus.rd = w_is_io ? w_io_rd : ((w_is_ram && !bus.misalign) ? w_ram_rd : 32'd0);
  assign irq    = r_irq;
  assign tx     = r_tx;

  // ---------------- RX engine ----------------
  logic        r_rx_s1, r_rx_s2, r_rx_s3, w_rx_tick;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [2:0]  r_rx_bit;
  assign w_rx_tick = r_rx_cnt == 16'd0;

  // Two-flop synchroniser plus one history flop for falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {r_rx_s1, r_rx_s2, r_rx_s3} <= 3'b111;
    else        {r_rx_s1, r_rx_s2, r_rx_s3} <= {rx, r_rx_s1, r_rx_s2};
  end

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= c_ST_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  // RX next state; rx_en only gates the start of a frame
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      c_ST_IDLE:  if (r_ctrl[0] && r_rx_s3 && !r_rx_s2) w_rx_next = c_ST_START;
      c_ST_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? c_ST_IDLE : c_ST_DATA;
      c_ST_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = c_ST_STOP;
      default:    if (w_rx_tick) w_rx_next = c_ST_IDLE;
    endcase
  end

  // RX outputs: stop-bit verdict
  always_comb begin
    w_rx_stop_ok  = 1'b0;
    w_rx_stop_bad = 1'b0;
    if (r_rx_state == c_ST_STOP && w_rx_tick) begin
      w_rx_stop_ok  = r_rx_s2;
      w_rx_stop_bad = !r_rx_s2;
    end
  end

  // RX bit timer and shift register; first sample lands mid start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt <= 16'd0;
      r_rx_div <= 16'd0;
      r_rx_bit <= 3'd0;
      r_rx_sh  <= 8'd0;
    end else if (r_rx_state == c_ST_IDLE) begin
      if (w_rx_next == c_ST_START) begin
        r_rx_div <= r_baud;
        r_rx_cnt <= (r_baud >> 1) - 16'd1;
      end
      r_rx_bit <= 3'd0;
    end else if (w_rx_tick) begin
      r_rx_cnt <= r_rx_div - 16'd1;
      if (r_rx_state == c_ST_DATA) begin
        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
    end else begin
      r_rx_cnt <= r_rx_cnt - 16'd1;
    end
  end

  // ---------------- TX engine ----------------
  logic [15:0] r_tx_cnt, r_tx_div;
  logic [2:0]  r_tx_bit;
  logic        w_tx_tick, w_tx_go;
  assign w_tx_tick = r_tx_cnt == 16'd0;
  assign w_tx_go   = r_ctrl[1] && !w_tx_empty;

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= c_ST_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  // TX next state; STOP chains straight into the next START when data waits
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      c_ST_IDLE:  if (w_tx_go) w_tx_next = c_ST_START;
      c_ST_START: if (w_tx_tick) w_tx_next = c_ST_DATA;
      c_ST_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = c_ST_STOP;
      default:    if (w_tx_tick) w_tx_next = w_tx_go ? c_ST_START : c_ST_IDLE;
    endcase
  end

  // TX outputs: FIFO pop at frame start and busy flag
  always_comb begin
    w_tx_pop  = w_tx_go && ((r_tx_state == c_ST_IDLE) ||
                            (r_tx_state == c_ST_STOP && w_tx_tick));
    w_tx_busy = r_tx_state != c_ST_IDLE;
  end

  // TX bit timer, shift register and registered line driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx     <= 1'b1;
      r_tx_cnt <= 16'd0;
      r_tx_div <= 16'd0;
      r_tx_bit <= 3'd0;
      r_tx_sh  <= 8'd0;
    end else if (w_tx_pop) begin
      r_tx     <= 1'b0;
      r_tx_div <= r_baud;
      r_tx_cnt <= r_baud - 16'd1;
      r_tx_sh  <= r_txf[r_tx_rp[c_PW-1:0]];
      r_tx_bit <= 3'd0;
    end else if (r_tx_state == c_ST_IDLE) begin
      r_tx <= 1'b1;
    end else if (w_tx_tick) begin
      r_tx_cnt <= r_tx_div - 16'd1;
      if (r_tx_state == c_ST_START) begin
        r_tx <= r_tx_sh[0];
      end else if (r_tx_state == c_ST_DATA && r_tx_bit != 3'd7) begin
        r_tx     <= r_tx_sh[1];
        r_tx_sh  <= r_tx_sh >> 1;
        r_tx_bit <= r_tx_bit + 3'd1;
      end else begin
        r_tx <= 1'b1;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt - 16'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_io_ram_uart_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_ram_uart_bus
// Description : Self-checking bench: RAM vector table, then UART TX/RX,
//               overrun/frame-error and mid-frame reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_ram_uart_bus;
  localparam logic [31:0] c_IOB = 32'h00400100;

  typedef struct {
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx, irq;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  io_ram_uart_bus_if bus ();

  io_ram_uart_bus #(
    .RAM_WORDS(1024), .IO_BASE(c_IOB), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd95)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rx(rx), .tx(tx), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                              input logic [31:0] wd, input logic chk, input logic [31:0] exp_rd,
                              input logic exp_mis);
    vec_t v;
    v.we = we; v.ctrl = ctrl; v.addr = addr; v.wd = wd;
    v.chk = chk; v.exp_rd = exp_rd; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Word store to an IO register; called at a negedge, returns one cycle later
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.address = a; bus.wd = d; bus.mem_ctrl = 3'd2; bus.we = 1'b1; bus.re = 1'b0;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    bus.address = a; bus.mem_ctrl = 3'd2; bus.we = 1'b0; bus.re = 1'b0;
    #1;
    d = bus.rd;
  endtask

  task automatic pop();
    bus.address = c_IOB + 32'h4; bus.mem_ctrl = 3'd2; bus.we = 1'b0; bus.re = 1'b1;
    @(negedge clk);
    bus.re = 1'b0;
  endtask

  // 8N1 frame at 8 clocks per bit
  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (8) @(negedge clk);
    end
    rx = stop;
    repeat (8) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[24];
    logic [31:0] d;
    logic [19:0] frames;
    logic        ok;

    bus.address = 32'd0; bus.wd = 32'd0; bus.we = 1'b0; bus.re = 1'b0; bus.mem_ctrl = 3'd2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- reset state ----
    rd_reg(c_IOB + 32'h00, d); check("rst_ctrl", d, 32'h0);
    rd_reg(c_IOB + 32'h0C, d); check("rst_baud", d, 32'd95);
    rd_reg(c_IOB + 32'h10, d); check("rst_status", d, 32'h05);
    rd_reg(c_IOB + 32'h04, d); check("rst_rxdata", d, 32'h0);
    rd_reg(c_IOB + 32'h08, d); check("rst_txdata", d, 32'h0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // ---- RAM / register vector table ----
    tv[0]  = mk(1, 3'd2, 32'h4,    32'h12345678, 0, 32'h0,        0);
    tv[1]  = mk(0, 3'd0, 32'h5,    32'h0,        1, 32'h00000056, 0);
    tv[2]  = mk(0, 3'd1, 32'h6,    32'h0,        1, 32'h00001234, 0);
    tv[3]  = mk(0, 3'd4, 32'h7,    32'h0,        1, 32'h00000012, 0);
    tv[4]  = mk(1, 3'd0, 32'h4,    32'h000000FF, 0, 32'h0,        0);
    tv[5]  = mk(0, 3'd0, 32'h4,    32'h0,        1, 32'hFFFFFFFF, 0);
    tv[6]  = mk(0, 3'd2, 32'h4,    32'h0,        1, 32'h123456FF, 0);
    tv[7]  = mk(1, 3'd2, 32'h6,    32'hDEADBEEF, 1, 32'h0,        1);
    tv[8]  = mk(0, 3'd2, 32'h4,    32'h0,        1, 32'h123456FF, 0);
    tv[9]  = mk(1, 3'd1, 32'h6,    32'h00008001, 0, 32'h0,        0);
    tv[10] = mk(0, 3'd1, 32'h6,    32'h0,        1, 32'hFFFF8001, 0);
    tv[11] = mk(0, 3'd5, 32'h6,    32'h0,        1, 32'h00008001, 0);
    tv[12] = mk(0, 3'd1, 32'h5,    32'h0,        1, 32'h0,        1);
    tv[13] = mk(0, 3'd3, 32'h4,    32'h0,        1, 32'h800156FF, 0);
    tv[14] = mk(1, 3'd2, 32'hFFC,  32'hCAFEF00D, 0, 32'h0,        0);
    tv[15] = mk(0, 3'd2, 32'hFFC,  32'h0,        1, 32'hCAFEF00D, 0);
    tv[16] = mk(0, 3'd2, 32'h1000, 32'h0,        1, 32'h0,        0);
    tv[17] = mk(1, 3'd1, 32'h5,    32'h0000BEEF, 1, 32'h0,        1);
    tv[18] = mk(0, 3'd2, 32'h4,    32'h0,        1, 32'h800156FF, 0);
    tv[19] = mk(0, 3'd7, 32'h4,    32'h0,        1, 32'h800156FF, 0);
    tv[20] = mk(1, 3'd2, c_IOB + 32'hC, 32'h1,   0, 32'h0,        0);
    tv[21] = mk(0, 3'd2, c_IOB + 32'hC, 32'h0,   1, 32'h4,        0);
    tv[22] = mk(1, 3'd2, c_IOB + 32'hC, 32'h123, 0, 32'h0,        0);
    tv[23] = mk(0, 3'd0, c_IOB + 32'hC, 32'h0,   1, 32'h123,      0);

    for (int i = 0; i < 24; i++) begin
      bus.address = tv[i].addr; bus.wd = tv[i].wd; bus.mem_ctrl = tv[i].ctrl;
      bus.we = tv[i].we; bus.re = 1'b0;
      #2;
      if (tv[i].chk) check($sformatf("vec%0d_rd", i), bus.rd, tv[i].exp_rd);
      check($sformatf("vec%0d_mis", i), {31'd0, bus.misalign}, {31'd0, tv[i].exp_mis});
      @(negedge clk);
    end
    bus.we = 1'b0;

    // ---- TX: two back-to-back frames at 4 clocks per bit ----
    wr(c_IOB + 32'h0C, 32'd4);
    wr(c_IOB + 32'h00, 32'd2);
    wr(c_IOB + 32'h08, 32'h5F);
    wr(c_IOB + 32'h08, 32'hA5);
    for (int i = 0; i < 20 && tx === 1'b1; i++) @(negedge clk);
    check("tx_start_seen", {31'd0, tx}, 32'd0);
    frames = {1'b1, 8'hA5, 1'b0, 1'b1, 8'h5F, 1'b0};
    for (int b = 0; b < 20; b++) begin
      ok = 1'b1;
      for (int s = 0; s < 4; s++) begin
        if (tx !== frames[b]) ok = 1'b0;
        if (b == 5 && s == 1) begin
          rd_reg(c_IOB + 32'h10, d);
          check("tx_busy_during", {31'd0, d[6]}, 32'd1);
        end
        @(negedge clk);
      end
      check($sformatf("tx_bit%0d", b), {31'd0, ok}, 32'd1);
    end
    check("tx_idle_line", {31'd0, tx}, 32'd1);
    rd_reg(c_IOB + 32'h10, d);
    check("tx_status_after", d & 32'h4C, 32'h04);

    // ---- RX: single byte, interrupt and pop ----
    wr(c_IOB + 32'h0C, 32'd8);
    wr(c_IOB + 32'h00, 32'd5);
    send_byte(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    check("rx_irq_set", {31'd0, irq}, 32'd1);
    rd_reg(c_IOB + 32'h04, d); check("rx_data", d, 32'h3C);
    pop();
    check("rx_irq_lag", {31'd0, irq}, 32'd1);
    rd_reg(c_IOB + 32'h10, d); check("rx_empty_after_pop", d & 32'h1, 32'h1);
    @(negedge clk);
    check("rx_irq_clear", {31'd0, irq}, 32'd0);

    // ---- RX overrun: nine frames without popping ----
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b1);
    repeat (2) @(negedge clk);
    rd_reg(c_IOB + 32'h10, d); check("ovr_status", d & 32'h13, 32'h12);
    for (int i = 0; i < 8; i++) begin
      rd_reg(c_IOB + 32'h04, d);
      check($sformatf("ovr_data%0d", i), d, 32'h10 + 32'(i));
      pop();
    end
    rd_reg(c_IOB + 32'h10, d); check("ovr_drained", d & 32'h13, 32'h11);

    // ---- frame error, then clear both sticky flags ----
    send_byte(8'h55, 1'b0);
    repeat (2) @(negedge clk);
    rd_reg(c_IOB + 32'h10, d); check("ferr_status", d & 32'h31, 32'h31);
    wr(c_IOB + 32'h10, 32'h30);
    rd_reg(c_IOB + 32'h10, d); check("sticky_cleared", d & 32'h30, 32'h0);

    // ---- asynchronous reset during a TX data bit ----
    wr(c_IOB + 32'h00, 32'd2);
    wr(c_IOB + 32'h08, 32'h00);
    wr(c_IOB + 32'h08, 32'h00);
    repeat (12) @(negedge clk);
    check("tx_mid_frame", {31'd0, tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_tx", {31'd0, tx}, 32'd1);
    check("rst_async_irq", {31'd0, irq}, 32'd0);
    rd_reg(c_IOB + 32'h00, d); check("rst2_ctrl", d, 32'h0);
    rd_reg(c_IOB + 32'h0C, d); check("rst2_baud", d, 32'd95);
    rd_reg(c_IOB + 32'h10, d); check("rst2_status", d & 32'h7F, 32'h05);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_tx_idle", {31'd0, tx}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
